// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
//   Serial-to-parallel 8N1 UART receive stage. The serial line is brought
//   into the clk_in domain through a two-flop synchroniser. The start bit is
//   validated at its middle. Each data bit and the stop bit are then sampled
//   at their centres, counting clk_baud ticks (OVERSAMPLE ticks per bit).
//   Completed bytes are offered on a registered valid/ready output. The
//   receiver also produces a one-cycle frame-error pulse and a one-cycle
//   overrun pulse.
//
// Ports
//   clk_in      system clock
//   rst_n       asynchronous, active-low reset
//   clk_baud    one-cycle tick enable at OVERSAMPLE x baud rate
//   rx_in       asynchronous serial line, idles high
//   data_out    received byte, stable while data_valid is high
//   data_valid  data_out holds an unconsumed byte
//   data_ready  consumer accepts data_out when high together with data_valid
//   frame_err   one-cycle pulse: stop bit sampled low, byte discarded
//   overrun     one-cycle pulse: new byte dropped, previous byte unconsumed
//   busy        high while a frame is being received
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 clk_baud,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    state_t               state_reg,      state_next;
    logic [TICK_W-1:0]    tick_cnt_reg,   tick_cnt_next;
    logic [BIT_W-1:0]     bit_idx_reg,    bit_idx_next;
    logic [DATA_BITS-1:0] shift_data_reg, shift_data_next;
    logic [DATA_BITS-1:0] data_out_reg,   data_out_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 frame_err_reg,  frame_err_next;
    logic                 overrun_reg,    overrun_next;
    logic                 stop_ok;
    logic                 consume;
    logic [DATA_BITS-1:0] shift_in;

    // LSB arrives first: each new sample enters at the MSB and moves down.
    generate
        if (DATA_BITS > 1) begin : g_shift_wide
            assign shift_in = {rx_s_reg, shift_data_reg[DATA_BITS-1:1]};
        end else begin : g_shift_single
            assign shift_in = rx_s_reg;
        end
    endgenerate

    // Synchroniser flops reset to the idle line level so that reset release
    // can never look like a start bit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg    <= 1'b1;
            rx_s_reg       <= 1'b1;
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_data_reg <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            rx_meta_reg    <= rx_in;
            rx_s_reg       <= rx_meta_reg;
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_data_reg <= shift_data_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_data_next = shift_data_reg;
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;
        stop_ok         = 1'b0;
        consume         = data_valid_reg & data_ready;

        case (state_reg)
            IDLE: begin
                // The falling edge is detected on any cycle, not only on ticks.
                if (!rx_s_reg) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (clk_baud) begin
                    if (tick_cnt_reg == TICK_MID) begin
                        if (!rx_s_reg) begin
                            state_next    = DATA;
                            tick_cnt_next = '0;
                            bit_idx_next  = '0;
                        end else begin
                            // The line went high again: treat it as a glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (clk_baud) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        shift_data_next = shift_in;
                        tick_cnt_next   = '0;
                        if (bit_idx_reg == BIT_LAST) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (clk_baud) begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        // Leave at mid stop bit so that the next start edge
                        // is caught with half a bit of margin.
                        state_next    = IDLE;
                        tick_cnt_next = '0;
                        if (rx_s_reg) begin
                            stop_ok = 1'b1;
                        end else begin
                            frame_err_next = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Output handshake. A byte that completes in the same cycle as a
        // consume replaces the old byte without a gap in data_valid.
        if (stop_ok) begin
            if (!data_valid_reg || consume) begin
                data_out_next   = shift_data_reg;
                data_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (consume) begin
            data_valid_next = 1'b0;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Directed testbench for uart_receiver. A behavioural transmitter drives
// rx_in, and a monitor counts the cycles on which each output is high.
// Each task checks its own expected values inline.
module tb_uart_receiver;
    localparam int OS = 16;

    logic       clk_in     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       clk_baud   = 1'b0;
    logic       rx_in      = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int baud_div = 1;
    int div_cnt  = 0;

    int valid_cyc = 0;
    int ferr_cyc  = 0;
    int ovr_cyc   = 0;
    int busy_cyc  = 0;

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .clk_baud  (clk_baud),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    // The baud tick is updated on the falling edge, so it is stable at each rising edge.
    always @(negedge clk_in) begin
        if (div_cnt >= baud_div - 1) div_cnt = 0;
        else div_cnt = div_cnt + 1;
        clk_baud = (div_cnt == 0);
    end

    // Cumulative high-cycle counters. Each task takes differences.
    always @(negedge clk_in) begin
        if (data_valid) valid_cyc = valid_cyc + 1;
        if (frame_err)  ferr_cyc  = ferr_cyc + 1;
        if (overrun)    ovr_cyc   = ovr_cyc + 1;
        if (busy)       busy_cyc  = busy_cyc + 1;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            while (!clk_baud) @(posedge clk_in);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_in);
        rx_in = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
        @(negedge clk_in);
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); end
        rst_n = 1'b1;
        idle(5);
        $display("reset: data_out=%h valid=%b busy=%b", data_out, data_valid, busy);
    endtask

    task automatic test_loopback();
        int v0, f0, o0;
        baud_div = 4;
        data_ready = 1'b1;
        idle(8);
        v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
        send_frame(8'hA5, 1'b1);
        idle(40);
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL loopback_data: got %h want a5", data_out); end
        total++; if (valid_cyc - v0 != 1) begin bad++; $display("FAIL loopback_valid_cycles: got %0d want 1", valid_cyc - v0); end
        total++; if (ferr_cyc - f0 != 0 || ovr_cyc - o0 != 0) begin bad++; $display("FAIL loopback_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cyc - f0, ovr_cyc - o0); end
        data_ready = 1'b0;
        $display("loopback: sent a5 got %h", data_out);
    endtask

    task automatic test_glitch();
        int v0, f0, o0, b0;
        baud_div = 1;
        idle(8);
        v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc; b0 = busy_cyc;
        @(negedge clk_in);
        rx_in = 1'b0;
        wait_ticks(4);
        @(negedge clk_in);
        rx_in = 1'b1;
        idle(40);
        total++; if (busy_cyc - b0 != 8) begin bad++; $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cyc - b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        total++; if (valid_cyc - v0 != 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", valid_cyc - v0); end
        total++; if (ferr_cyc - f0 != 0 || ovr_cyc - o0 != 0) begin bad++; $display("FAIL glitch_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cyc - f0, ovr_cyc - o0); end
        $display("glitch: busy_cycles=%0d", busy_cyc - b0);
    endtask

    task automatic test_frame_err();
        int v0, f0, o0;
        v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
        send_frame(8'h3C, 1'b0);
        idle(60);
        total++; if (ferr_cyc - f0 != 1) begin bad++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cyc - f0); end
        total++; if (valid_cyc - v0 != 0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", valid_cyc - v0); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL ferr_data_kept: got %h want a5", data_out); end
        total++; if (ovr_cyc - o0 != 0) begin bad++; $display("FAIL ferr_overrun: got %0d want 0", ovr_cyc - o0); end
        $display("frame_err: pulses=%0d data_out=%h", ferr_cyc - f0, data_out);
    endtask

    task automatic test_back_to_back();
        int f0, o0;
        f0 = ferr_cyc; o0 = ovr_cyc;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        total++; if (data_out !== 8'h11) begin bad++; $display("FAIL b2b_data: got %h want 11", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
        total++; if (ovr_cyc - o0 != 1) begin bad++; $display("FAIL b2b_overrun: got %0d want 1", ovr_cyc - o0); end
        total++; if (ferr_cyc - f0 != 0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cyc - f0); end
        data_ready = 1'b1;
        @(negedge clk_in);
        data_ready = 1'b0;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL b2b_consume: got %b want 0", data_valid); end
        idle(5);
        $display("back_to_back: data_out=%h overruns=%0d", data_out, ovr_cyc - o0);
    endtask

    task automatic test_ready_same_cycle();
        int o0;
        o0 = ovr_cyc;
        data_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        idle(4);
        total++; if (data_out !== 8'h55 || data_valid !== 1'b1) begin bad++; $display("FAIL same_first: got %h/%b want 55/1", data_out, data_valid); end
        // With a tick on every cycle, the stop bit is sampled 155 rising edges
        // after the start bit is driven. data_ready must be high on that edge.
        fork
            send_frame(8'hAA, 1'b1);
            begin
                @(negedge clk_in);
                repeat (154) @(posedge clk_in);
                @(negedge clk_in);
                total++; if (data_out !== 8'h55) begin bad++; $display("FAIL same_hold: got %h want 55", data_out); end
                data_ready = 1'b1;
                @(negedge clk_in);
                data_ready = 1'b0;
            end
        join
        idle(10);
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL same_valid: got %b want 1", data_valid); end
        total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL same_data: got %h want aa", data_out); end
        total++; if (ovr_cyc - o0 != 0) begin bad++; $display("FAIL same_overrun: got %0d want 0", ovr_cyc - o0); end
        data_ready = 1'b1;
        @(negedge clk_in);
        data_ready = 1'b0;
        idle(5);
        $display("ready_same_cycle: data_out=%h valid=%b", data_out, data_valid);
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0, o0;
        v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge clk_in);
                repeat (OS * 5 + 8) @(posedge clk_in);
                @(negedge clk_in);
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
                rst_n = 1'b0;
                #1;
                total++; if (busy !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL midrst_async: got busy=%b data=%h want 0/00", busy, data_out); end
                idle(3);
                rst_n = 1'b1;
            end
        join
        idle(10);
        send_frame(8'h81, 1'b1);
        idle(10);
        total++; if (data_out !== 8'h81 || data_valid !== 1'b1) begin bad++; $display("FAIL midrst_data: got %h/%b want 81/1", data_out, data_valid); end
        total++; if (valid_cyc - v0 == 0 || ferr_cyc - f0 != 0 || ovr_cyc - o0 != 0) begin bad++; $display("FAIL midrst_flags: got valid=%0d ferr=%0d ovr=%0d want >0 0 0", valid_cyc - v0, ferr_cyc - f0, ovr_cyc - o0); end
        $display("reset_mid_frame: data_out=%h", data_out);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_ready_same_cycle();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
